// File: rtl/ftdi_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the FT60x TX path from up to 8 AXI4-Stream
// sources, with an optional one-beat channel header in front of every packet.
module ftdi_tx_arbiter #(
  parameter int         NUM_CH      = 4,
  parameter int         TDATA_WIDTH = 4,
  parameter int         HDR_EN      = 1,
  parameter logic [7:0] HDR_MAGIC   = 8'hA5
) (
  input  logic                            tx_clk,
  input  logic                            rst_txclk,
  input  logic [NUM_CH-1:0]               ch_en,
  input  logic [NUM_CH-1:0]               s_axis_tvalid,
  output logic [NUM_CH-1:0]               s_axis_tready,
  input  logic [NUM_CH*TDATA_WIDTH*8-1:0] s_axis_tdata,
  input  logic [NUM_CH*TDATA_WIDTH-1:0]   s_axis_tstrb,
  input  logic [NUM_CH*TDATA_WIDTH-1:0]   s_axis_tkeep,
  input  logic [NUM_CH-1:0]               s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [TDATA_WIDTH*8-1:0]        m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]          m_axis_tstrb,
  output logic [TDATA_WIDTH-1:0]          m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [2:0]                      grant_ch,
  output logic                            busy
);

  localparam int DW = TDATA_WIDTH * 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [2:0]             grant_q, grant_d;
  logic [2:0]             last_grant_q, last_grant_d;
  logic [NUM_CH-1:0]      req;
  logic                   found;
  int                     idx;

  logic                   sel_valid;
  logic                   sel_last;
  logic [DW-1:0]          sel_data;
  logic [TDATA_WIDTH-1:0] sel_strb;
  logic [TDATA_WIDTH-1:0] sel_keep;
  logic [DW-1:0]          hdr_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_strb  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (3'(i) == grant_q) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DW +: DW];
        sel_strb  = s_axis_tstrb[i*TDATA_WIDTH +: TDATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  // Round-robin scan starts one past the last completed grant and wraps modulo NUM_CH.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req          = s_axis_tvalid & ch_en;
    found        = 1'b0;
    idx          = 0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_CH;
            if (!found && req[idx]) begin
              found   = 1'b1;
              grant_d = 3'(idx);
            end
          end
          state_d = (HDR_EN != 0) ? S_HDR : S_DATA;
        end
      end
      S_HDR: begin
        if (m_axis_tready) state_d = S_DATA;
      end
      S_DATA: begin
        if (sel_valid && m_axis_tready && sel_last) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst_txclk) begin
      state_q      <= S_IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    hdr_data       = '0;
    hdr_data[7:0]  = HDR_MAGIC;
    hdr_data[15:8] = {5'b0, grant_q};
  end

  // Outputs are purely a function of state so reset clears them on the very next cycle.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      S_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_data;
        m_axis_tstrb  = '1;
        m_axis_tkeep  = '1;
      end
      S_DATA: begin
        m_axis_tvalid = sel_valid;
        m_axis_tdata  = sel_data;
        m_axis_tstrb  = sel_strb;
        m_axis_tkeep  = sel_keep;
        m_axis_tlast  = sel_last;
        for (int i = 0; i < NUM_CH; i++) begin
          if (3'(i) == grant_q) s_axis_tready[i] = m_axis_tready;
        end
      end
      default: ;
    endcase
  end

  assign grant_ch = grant_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Scoreboard bench for ftdi_tx_arbiter: one DUT with headers, one without, sharing the
// bench source model that replays per-channel beat stores.
module tb_ftdi_tx_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  s;
    logic        l;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   chEn, chEn0;
  logic [3:0]   sValid, sReady, sReady0, sLast;
  logic [127:0] sData;
  logic [15:0]  sKeep, sStrb;
  logic         mReady;

  logic         mValid, mLast, busy;
  logic [31:0]  mData;
  logic [3:0]   mKeep, mStrb;
  logic [2:0]   grantCh;

  logic         o0Valid, o0Last, busy0;
  logic [31:0]  o0Data;
  logic [3:0]   o0Keep, o0Strb;
  logic [2:0]   grant0;

  logic [31:0]  srcData[4][64];
  logic [3:0]   srcKeep[4][64];
  logic [3:0]   srcStrb[4][64];
  logic         srcLast[4][64];
  int           head[4];
  int           tail[4];

  exp_t         sbQ[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic         prevLast = 1'b0;
  logic         prevStall = 1'b0;
  logic [31:0]  prevData = '0;

  always #5 clock = ~clock;

  ftdi_tx_arbiter #(.NUM_CH(4), .TDATA_WIDTH(4), .HDR_EN(1), .HDR_MAGIC(8'hA5)) dut (
    .tx_clk(clock), .rst_txclk(reset), .ch_en(chEn),
    .s_axis_tvalid(sValid), .s_axis_tready(sReady), .s_axis_tdata(sData),
    .s_axis_tstrb(sStrb), .s_axis_tkeep(sKeep), .s_axis_tlast(sLast),
    .m_axis_tvalid(mValid), .m_axis_tready(mReady), .m_axis_tdata(mData),
    .m_axis_tstrb(mStrb), .m_axis_tkeep(mKeep), .m_axis_tlast(mLast),
    .grant_ch(grantCh), .busy(busy)
  );

  ftdi_tx_arbiter #(.NUM_CH(4), .TDATA_WIDTH(4), .HDR_EN(0), .HDR_MAGIC(8'hA5)) dut0 (
    .tx_clk(clock), .rst_txclk(reset), .ch_en(chEn0),
    .s_axis_tvalid(sValid), .s_axis_tready(sReady0), .s_axis_tdata(sData),
    .s_axis_tstrb(sStrb), .s_axis_tkeep(sKeep), .s_axis_tlast(sLast),
    .m_axis_tvalid(o0Valid), .m_axis_tready(mReady), .m_axis_tdata(o0Data),
    .m_axis_tstrb(o0Strb), .m_axis_tkeep(o0Keep), .m_axis_tlast(o0Last),
    .grant_ch(grant0), .busy(busy0)
  );

  function automatic logic [31:0] beatData(int ch, int pkt, int b);
    return {8'(ch), 8'(pkt), 8'(b), 8'hD0};
  endfunction

  function automatic logic [3:0] beatKeep(int b, int n);
    return (b == n - 1) ? 4'h7 : 4'hF;
  endfunction

  function automatic logic [3:0] beatStrb(int b, int n);
    return beatKeep(b, n) & (((b % 2) == 1) ? 4'hE : 4'hF);
  endfunction

  task automatic checkOutput(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(int ch, int pkt, int n);
    for (int b = 0; b < n; b++) begin
      srcData[ch][tail[ch]] = beatData(ch, pkt, b);
      srcKeep[ch][tail[ch]] = beatKeep(b, n);
      srcStrb[ch][tail[ch]] = beatStrb(b, n);
      srcLast[ch][tail[ch]] = (b == n - 1);
      tail[ch]++;
    end
  endtask

  task automatic expectHeader(int ch);
    exp_t e;
    e.d = {16'h0, 5'b0, 3'(ch), 8'hA5};
    e.k = 4'hF;
    e.s = 4'hF;
    e.l = 1'b0;
    sbQ.push_back(e);
  endtask

  task automatic expectBeat(int ch, int pkt, int b, int n);
    exp_t e;
    e.d = beatData(ch, pkt, b);
    e.k = beatKeep(b, n);
    e.s = beatStrb(b, n);
    e.l = (b == n - 1);
    sbQ.push_back(e);
  endtask

  task automatic expectPacket(int ch, int pkt, int n);
    expectHeader(ch);
    for (int b = 0; b < n; b++) expectBeat(ch, pkt, b, n);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flushSources();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("rst_tvalid", mValid, 0);
    checkOutput("rst_tlast", mLast, 0);
    checkOutput("rst_tdata", mData, 0);
    checkOutput("rst_tkeep_tstrb", {mKeep, mStrb}, 0);
    checkOutput("rst_tready", sReady, 0);
    checkOutput("rst_busy_grant", {busy, grantCh}, 0);
    tick();
    reset = 1'b0;
    flushSources();
    sbQ.delete();
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (sbQ.size() == 0 && !busy && !busy0) break;
    end
    checkOutput("drain_sb", sbQ.size(), 0);
    checkOutput("drain_busy", {busy, busy0}, 0);
    tick();
  endtask

  // Source model: present the head beat of each channel shortly after every rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      for (int i = 0; i < 4; i++) begin
        if (head[i] != tail[i]) begin
          sValid[i]          = 1'b1;
          sData[i*32 +: 32]  = srcData[i][head[i]];
          sKeep[i*4 +: 4]    = srcKeep[i][head[i]];
          sStrb[i*4 +: 4]    = srcStrb[i][head[i]];
          sLast[i]           = srcLast[i][head[i]];
        end else begin
          sValid[i]          = 1'b0;
          sData[i*32 +: 32]  = '0;
          sKeep[i*4 +: 4]    = '0;
          sStrb[i*4 +: 4]    = '0;
          sLast[i]           = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pops, AXIS hold rule and the mandatory idle gap.
  initial begin
    forever begin
      @(negedge clock);
      if (prevLast) checkOutput("gap_idle", mValid, 0);
      if (prevStall) begin
        checkOutput("hold_valid", mValid, 1);
        checkOutput("hold_data", mData, prevData);
      end
      if (mValid && mReady) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_underflow", sbQ.size(), 1);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("sb_data", mData, e.d);
          checkOutput("sb_keep", mKeep, e.k);
          checkOutput("sb_strb", mStrb, e.s);
          checkOutput("sb_last", mLast, e.l);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (sValid[i] && (sReady[i] || sReady0[i]) && head[i] != tail[i]) head[i]++;
      end
      prevLast  = mValid && mReady && mLast && !reset;
      prevStall = mValid && !mReady && !reset;
      prevData  = mData;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic seen;
    logic inData;
    reset   = 1'b1;
    chEn    = 4'hF;
    chEn0   = 4'h0;
    mReady  = 1'b1;
    sValid  = '0;
    sLast   = '0;
    sData   = '0;
    sKeep   = '0;
    sStrb   = '0;
    flushSources();
    tick();

    $display("[TB] source 0 alone, header latency");
    doReset();
    applyStimulus(0, 0, 3);
    expectPacket(0, 0, 3);
    @(negedge clock);
    checkOutput("lat_idle_valid", {mValid, busy}, 0);
    @(negedge clock);
    checkOutput("lat_hdr_valid", mValid, 1);
    checkOutput("lat_hdr_data", mData, 32'h0000_00A5);
    checkOutput("lat_hdr_busy_grant", {busy, grantCh}, {1'b1, 3'd0});
    checkOutput("lat_hdr_rdy", sReady, 0);
    tick();
    waitDrain();

    $display("[TB] fairness with all sources requesting");
    doReset();
    applyStimulus(0, 0, 2);
    applyStimulus(0, 1, 2);
    applyStimulus(1, 0, 2);
    applyStimulus(1, 1, 2);
    applyStimulus(2, 0, 2);
    applyStimulus(3, 0, 2);
    expectPacket(0, 0, 2);
    expectPacket(1, 0, 2);
    expectPacket(2, 0, 2);
    expectPacket(3, 0, 2);
    expectPacket(0, 1, 2);
    expectPacket(1, 1, 2);
    waitDrain();

    $display("[TB] backpressure");
    doReset();
    mReady = 1'b0;
    applyStimulus(2, 0, 3);
    expectPacket(2, 0, 3);
    expectPacket(0, 0, 2);
    tick();
    applyStimulus(0, 0, 2);
    inData = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (busy && grantCh == 3'd2) begin
        checkOutput("bp_rdy_others", {sReady[3], sReady[1], sReady[0]}, 0);
        checkOutput("bp_rdy_granted", sReady[2], inData & mReady);
        if (mValid && mReady) begin
          if (!inData) inData = 1'b1;
          else if (mLast) inData = 1'b0;
        end
      end
      if (sbQ.size() == 0 && !busy) break;
      tick();
      mReady = ~mReady;
    end
    checkOutput("bp_drain", sbQ.size(), 0);
    tick();
    mReady = 1'b1;
    waitDrain();

    $display("[TB] ch_en masking");
    doReset();
    chEn = 4'b0101;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, p, 3);
      applyStimulus(2, p, 4);
    end
    applyStimulus(1, 0, 2);
    applyStimulus(3, 0, 2);
    expectPacket(0, 0, 3);
    expectPacket(2, 0, 4);
    expectPacket(0, 1, 3);
    expectPacket(2, 1, 4);
    expectPacket(0, 2, 3);
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (mValid && mReady && mData == beatData(2, 1, 1)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("mask_midpkt_seen", seen, 1);
    tick();
    chEn = 4'b0001;
    waitDrain();
    repeat (6) tick();
    @(negedge clock);
    checkOutput("mask_idle", {busy, mValid, sReady}, 0);
    tick();

    $display("[TB] no-header single beat");
    doReset();
    chEn  = 4'h0;
    chEn0 = 4'hF;
    applyStimulus(3, 0, 1);
    @(negedge clock);
    checkOutput("nohdr_idle", {o0Valid, busy0}, 0);
    @(negedge clock);
    checkOutput("nohdr_valid_last", {o0Valid, o0Last}, 2'b11);
    checkOutput("nohdr_data", o0Data, beatData(3, 0, 0));
    checkOutput("nohdr_keep_strb", {o0Keep, o0Strb}, {beatKeep(0, 1), beatStrb(0, 1)});
    checkOutput("nohdr_busy_grant", {busy0, grant0}, {1'b1, 3'd3});
    checkOutput("nohdr_rdy", sReady0, 4'b1000);
    @(negedge clock);
    checkOutput("nohdr_done", {busy0, o0Valid}, 0);
    tick();
    chEn  = 4'hF;
    chEn0 = 4'h0;

    $display("[TB] reset mid-packet");
    doReset();
    applyStimulus(0, 0, 2);
    expectPacket(0, 0, 2);
    waitDrain();
    applyStimulus(1, 0, 5);
    expectHeader(1);
    expectBeat(1, 0, 0, 5);
    expectBeat(1, 0, 1, 5);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (mValid && mReady && mData == beatData(1, 0, 1)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rstmid_seen", seen, 1);
    reset = 1'b1;
    tick();
    flushSources();
    @(negedge clock);
    checkOutput("rstmid_valid_last", {mValid, mLast}, 0);
    checkOutput("rstmid_data", {mData, mKeep, mStrb}, 0);
    checkOutput("rstmid_rdy_busy", {sReady, busy, grantCh}, 0);
    checkOutput("rstmid_sb", sbQ.size(), 0);
    tick();
    reset = 1'b0;
    sbQ.delete();
    applyStimulus(1, 1, 2);
    applyStimulus(0, 1, 2);
    expectPacket(0, 1, 2);
    expectPacket(1, 1, 2);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
# ftdi_tx_arbiter

Packet-level round-robin arbiter that shares the FT60x transmit path among up to 8 AXI4-Stream sources in the `tx_clk` domain. It sits in front of the TX width converter and TX packet FIFO. It grants one source at a time for a whole packet (through `tlast`) and can prepend a one-beat channel header so the host can demultiplex the streams.

## Interface
- `NUM_CH`, 4: number of requesting sources, 2-8.
- `TDATA_WIDTH`, 4: data width in bytes, 2-64, for all ports.
- `HDR_EN`, 1: 1 = prepend a header beat to each packet; 0 = no header.
- `HDR_MAGIC`, 8'hA5: header byte 0.

Ports:
- `tx_clk`  in  1  module clock.
- `rst_txclk`  in  1  reset, synchronous, active-high.
- `ch_en`  in  NUM_CH  per-source enable; sampled only in IDLE.
- `s_axis_tvalid`  in  NUM_CH  per-source valid.
- `s_axis_tready`  out  NUM_CH  per-source ready.
- `s_axis_tdata`  in  NUM_CH*TDATA_WIDTH*8  flattened data; source i occupies slice i.
- `s_axis_tstrb`  in  NUM_CH*TDATA_WIDTH  flattened strobe.
- `s_axis_tkeep`  in  NUM_CH*TDATA_WIDTH  flattened keep.
- `s_axis_tlast`  in  NUM_CH  per-source last.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tdata`  out  TDATA_WIDTH*8  output data.
- `m_axis_tstrb`  out  TDATA_WIDTH  output strobe.
- `m_axis_tkeep`  out  TDATA_WIDTH  output keep.
- `m_axis_tlast`  out  1  output last.
- `grant_ch`  out  3  index of the current or last granted source.
- `busy`  out  1  high in HDR and DATA.

## Operation
- **State machine:** IDLE, HDR, DATA.
- **IDLE**
  - Request vector = `s_axis_tvalid & ch_en`.
  - If the vector is nonzero, select the first requesting index scanning upward from `last_grant+1`, wrapping modulo NUM_CH.
  - Register the selection into `grant_ch`.
  - Go to HDR if HDR_EN=1, else go to DATA.
  - All outputs are deasserted in IDLE.
- **HDR**
  - `m_axis_tvalid`=1.
  - `tdata` byte0 = HDR_MAGIC, byte1 = {5'b0, grant_ch}, all other bytes 0.
  - `tkeep` and `tstrb` all ones; `tlast`=0.
  - All `s_axis_tready`=0.
  - On `m_axis_tready`=1, go to DATA.
- **DATA**
  - Combinational pass-through of the granted slice.
  - `m_axis_tvalid` = `s_axis_tvalid[g]`; `s_axis_tready[g]` = `m_axis_tready`; all other readies = 0.
  - `tdata`, `tstrb`, `tkeep`, `tlast` come from slice g.
  - On a handshake with `tlast`=1, set `last_grant`←g and go to IDLE.
- **`ch_en`:** deasserting `ch_en[g]` mid-packet does not abort the packet. The packet completes, and the channel is then excluded from subsequent arbitration.
- **Fairness:** with all sources continuously requesting, grants rotate 0,1,2,…,NUM_CH-1,0. No source waits more than NUM_CH-1 packets.
- **Illegal grant index:** `grant_ch` ≥ NUM_CH is never produced.

## Timing
- **Reset values:**
  - `m_axis_tvalid`=0, `s_axis_tready`=0, `m_axis_tlast`=0.
  - `m_axis_tdata`, `tstrb`, `tkeep` = 0.
  - `busy`=0, `grant_ch`=0, state=IDLE.
  - `last_grant`=NUM_CH-1, so source 0 wins first.
- **Reset mid-packet:**
  - Outputs return to reset values the cycle after `rst_txclk` is sampled high.
  - The partial packet is dropped from the arbiter's view; upstream and downstream are reset by the same `rst_txclk`.
- **Grant latency:** valid seen in IDLE at cycle N → HDR beat valid at N+1. With HDR_EN=0, data beat valid at N+1.
- **Gap:**
  - One IDLE cycle between packets, so back-to-back packets from the same or different sources have exactly 1 dead cycle.
  - With HDR_EN=1, packet overhead is 1 header beat + 1 idle cycle.
- **DATA throughput:** 1 beat per cycle when the granted source is valid and `m_axis_tready`=1. Backpressure propagates combinationally in the same cycle.
- **Holding during backpressure:** HDR holds `tvalid` and `tdata` stable until accepted; no AXIS stability violation is allowed on any output.
- **Simultaneous events:** a new request arriving during DATA is not considered until IDLE. A `tlast` handshake and a new request on the same cycle → grant on the next cycle (IDLE), header on the one after.
- **Single-beat packet:** `tvalid` and `tlast` both high on the first DATA beat → returns to IDLE after that one beat.

## Test plan
- **Reset, then source 0 only:**
  - Stimulus: HDR_EN=1, NUM_CH=4, `ch_en`=4'hF; source 0 sends a 3-beat packet D0..D2.
  - Required response: output = header 0x000000A5 (byte1=0), then D0, D1, D2 with `tlast` on D2. Header appears 1 cycle after `tvalid` rises.
- **All four sources requesting continuously with 2-beat packets:**
  - Required response: header channel fields are 0,1,2,3,0,1. Exactly 1 idle cycle between packets; no interleaving of beats.
- **Backpressure:**
  - Stimulus: toggle `m_axis_tready` 1/0 every cycle during HDR and DATA.
  - Required response: header is held stable until accepted. The granted `s_axis_tready` mirrors `m_axis_tready`; non-granted readies stay 0.
- **`ch_en` masking:**
  - Stimulus: `ch_en`=4'b0101, all sources valid; then clear `ch_en[2]` mid-packet of source 2.
  - Required response: grants alternate 0,2,0,2. The packet from source 2 in progress completes; after it, only 0 is granted.
- **HDR_EN=0 with a single-beat packet:**
  - Stimulus: source 3 sends one beat with `tlast`.
  - Required response: output beat equals source 3's beat 1 cycle after its `tvalid`; `busy` high for 1 cycle.
- **Reset mid-packet:**
  - Stimulus: assert `rst_txclk` during beat 2 of a 5-beat packet.
  - Required response: next cycle all outputs are at reset values. After reset, source 0 wins regardless of the prior grant.
